// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the LIFO stack: width helpers and the per-cycle action
// encoding used by the control decode.
package lifo_pkg;

    typedef enum logic [2:0] {
        ACT_NOP    = 3'd0,
        ACT_PUSH   = 3'd1,
        ACT_POP    = 3'd2,
        ACT_SWAP   = 3'd3,
        ACT_BYPASS = 3'd4
    } lifo_act_e;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to address 0..depth-1.
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Rejected operations (push on full, pop on empty) decode to NOP; the error
    // flags are derived separately so the action stays a pure datapath selector.
    function automatic lifo_act_e decode_action(input logic push,
                                                input logic pop,
                                                input logic full,
                                                input logic empty);
        lifo_act_e act;
        act = ACT_NOP;
        if (push && pop) begin
            act = empty ? ACT_BYPASS : ACT_SWAP;
        end else if (push) begin
            act = full ? ACT_NOP : ACT_PUSH;
        end else if (pop) begin
            act = empty ? ACT_NOP : ACT_POP;
        end
        return act;
    endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Bus bundle between a stack user (master) and the lifo_stack (slave).
interface lifo_stack_if
    import lifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              pop_valid;
    logic [DATA_W-1:0] top;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, data_in, clr_err,
        input  data_out, pop_valid, top, count, full, empty,
               almost_full, overflow, underflow
    );

    modport slave (
        input  push, pop, data_in, clr_err,
        output data_out, pop_valid, top, count, full, empty,
               almost_full, overflow, underflow
    );

endinterface

// File: rtl/lifo_stack_mem.sv
// Stack storage: one synchronous write port and two asynchronous read ports.
// Addresses outside 0..DEPTH-1 never write and read back as zero.
module lifo_mem
    import lifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    localparam int               AW  = addr_width(DEPTH);
    localparam logic [IDX_W-1:0] LIM = IDX_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (waddr < LIM)) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata_a = (raddr_a < LIM) ? mem[raddr_a[AW-1:0]] : '0;
    assign rdata_b = (raddr_b < LIM) ? mem[raddr_b[AW-1:0]] : '0;

endmodule

// File: rtl/lifo_stack.sv
// Parametrised hardware stack with simultaneous push/pop, combinational top peek,
// occupancy flags and sticky overflow/underflow.
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input logic          clk,
    input logic          rst_n,
    lifo_stack_if.slave  bus
);
    localparam int               CNT_W   = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] data_out_q;
    logic              pop_valid_q;
    logic              overflow_q;
    logic              underflow_q;

    logic              full;
    logic              empty;
    lifo_act_e         act;
    logic              push_rej;
    logic              pop_rej;

    logic [CNT_W-1:0]  top_idx;
    logic              mem_we;
    logic [CNT_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] rd_top;
    logic [DATA_W-1:0] rd_pop;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign act      = decode_action(bus.push, bus.pop, full, empty);
    assign push_rej = bus.push && !bus.pop && full;
    assign pop_rej  = bus.pop && !bus.push && empty;

    // When empty this wraps to all-ones, which the memory reads back as zero.
    assign top_idx  = count_q - ONE_C;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = count_q;
        case (act)
            ACT_PUSH: begin
                mem_we    = 1'b1;
                mem_waddr = count_q;
            end
            ACT_SWAP: begin
                mem_we    = 1'b1;
                mem_waddr = top_idx;
            end
            default: begin
                mem_we    = 1'b0;
                mem_waddr = count_q;
            end
        endcase
    end

    lifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (CNT_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (bus.data_in),
        .raddr_a (top_idx),
        .rdata_a (rd_top),
        .raddr_b (top_idx),
        .rdata_b (rd_pop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            data_out_q  <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            pop_valid_q <= 1'b0;
            case (act)
                ACT_PUSH: begin
                    count_q <= count_q + ONE_C;
                end
                ACT_POP: begin
                    count_q     <= top_idx;
                    data_out_q  <= rd_pop;
                    pop_valid_q <= 1'b1;
                end
                ACT_SWAP: begin
                    data_out_q  <= rd_pop;
                    pop_valid_q <= 1'b1;
                end
                ACT_BYPASS: begin
                    data_out_q  <= bus.data_in;
                    pop_valid_q <= 1'b1;
                end
                default: begin
                    count_q <= count_q;
                end
            endcase
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= push_rej || (overflow_q && !bus.clr_err);
            underflow_q <= pop_rej || (underflow_q && !bus.clr_err);
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.pop_valid   = pop_valid_q;
    assign bus.top         = empty ? '0 : rd_top;
    assign bus.count       = count_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (count_q >= AFULL_C);
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule
